spike_aer_arbiter: RTL and testbench
====================================

SPIKE_AER_ARBITER -- requirements
Module: spike_aer_arbiter

Interface
REQ-001 The block SHALL have parameter N_NEUR, default 4: number of neuron spike inputs arbitrated (2..16).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter TS_W, default 16: timestamp width; ADDR_W SHALL be derived as $clog2(N_NEUR).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  1 = accept new spikes and advance timestamp; 0 = ignore spike_in, freeze timestamp, keep draining.
REQ-007 spike_in  input  N_NEUR  one-cycle spike pulses from neurons; bit i = neuron i.
REQ-008 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 ev_valid  output  1  FIFO head holds an event.
REQ-010 ev_ready  input  1  consumer accepts head when ev_valid & ev_ready.
REQ-011 ev_addr  output  ADDR_W  neuron index of head event.
REQ-012 ev_ts  output  TS_W  timestamp of head event.
REQ-013 pending  output  N_NEUR  latched, not-yet-queued spikes.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
REQ-015 overflow  output  1  sticky: a spike was merged into an already-pending bit.

Function
REQ-016 A free-running counter ts SHALL increment by 1 each cycle with en=1, wrapping from 2^TS_W-1 to 0.
REQ-017 With en=1, at each edge pending[i] SHALL be set when spike_in[i]=1, independent of other bits.
REQ-018 Each cycle with pending!=0 and fifo_count<FIFO_DEPTH, exactly one bit SHALL be granted, round-robin from (last_grant+1) mod N_NEUR upward with wrap.
REQ-019 A grant SHALL push {addr=i, ts=current ts} at that edge, clear pending[i], and set last_grant=i.
REQ-020 When spike_in[i]=1 in the same cycle pending[i] is granted, pending[i] SHALL remain 1 (new event, no overflow).
REQ-021 When spike_in[i]=1 while pending[i]=1 and i is not granted, overflow SHALL be set to 1; the spike is merged.
REQ-022 When the FIFO is full, no grant SHALL occur that cycle, even if a pop occurs in the same cycle.
REQ-023 Latency: a spike sampled at edge t SHALL be pushed no earlier than edge t+1, with ev_valid high from cycle t+2 when the FIFO was empty and the bit won arbitration.
REQ-024 FIFO SHALL be first-word-fall-through; ev_addr/ev_ts SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-025 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged.
REQ-026 ev_ready with ev_valid=0 SHALL have no effect.
REQ-027 clr_ovf=1 SHALL clear overflow at the next edge; an overflow event in that same cycle SHALL win (overflow stays 1).

Reset
REQ-028 While rst=1: ts=0, pending=0, last_grant=N_NEUR-1 (first grant starts at 0), FIFO empty, fifo_count=0, ev_valid=0, overflow=0, ev_addr=0, ev_ts=0.
REQ-029 Reset mid-operation SHALL discard all pending and queued events; no event SHALL emerge after reset release without a new spike.

Structure
REQ-030 A shared package snn_pkg SHALL hold the event struct typedef (addr, ts) and default N_NEUR/FIFO_DEPTH/TS_W constants.
REQ-031 The FIFO SHALL be a separate sub-module spike_event_fifo (parameterised depth/width, valid/ready pop, push/full).

Verification
REQ-032 Reset, then spike_in=4'b0001 for one cycle (en=1) -> one event addr=0, ts = counter at grant, ev_valid 2 cycles after spike edge.
REQ-033 spike_in=4'b1111 in one cycle, ev_ready=1 -> events addr 0,1,2,3 in order on consecutive cycles, pending drains to 0, overflow=0.
REQ-034 ev_ready=0, spike all 4 neurons each cycle for 4 cycles -> fifo_count saturates at 8, no grant while full, overflow=1; clr_ovf pulse with no spikes -> overflow=0.
REQ-035 Repeated spike on neuron 2 every cycle while granted each cycle -> pending[2] stays 1, no overflow, ts values strictly consecutive.
REQ-036 TS_W=4, run 20 cycles with one spike at ts=15 and next cycle -> ts=15 then 0 observed.
REQ-037 Assert rst asynchronously with fifo_count=5 and pending=4'b0110 -> all outputs reset immediately, no events after release.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron event path: default sizing
// constants, the address-event record and the round-robin index helper.
package snn_pkg;

    localparam int SNN_N_NEUR     = 4;
    localparam int SNN_FIFO_DEPTH = 8;
    localparam int SNN_TS_W       = 16;
    localparam int SNN_ADDR_W     = $clog2(SNN_N_NEUR);

    // One address event in the default configuration: which neuron, and when.
    typedef struct packed {
        logic [SNN_ADDR_W-1:0] addr;
        logic [SNN_TS_W-1:0]   ts;
    } snn_event_t;

    // Candidate neuron index 'offset' positions after 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO. The head word is presented as soon as
// it is written and stays put until the consumer takes it with pop_ready.
// Pushes while full are dropped; the arbiter never issues one.
module spike_event_fifo #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == CNT_W'(DEPTH));
    assign pop_valid = (cnt != '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop_valid & pop_ready;
    // Head is forced to zero when empty so stale storage never shows.
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;
    assign count     = cnt;

    // Event storage: data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Address-event arbiter: latches one-cycle neuron spikes into a pending
// vector, grants one pending neuron per cycle in round-robin order, and
// queues {neuron index, timestamp} events into a FWFT FIFO for the consumer.
module spike_aer_arbiter
    import snn_pkg::*;
#(
    parameter int N_NEUR     = SNN_N_NEUR,
    parameter int FIFO_DEPTH = SNN_FIFO_DEPTH,
    parameter int TS_W       = SNN_TS_W,
    localparam int ADDR_W    = $clog2(N_NEUR),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_NEUR-1:0] spike_in,
    input  logic              clr_ovf,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [TS_W-1:0]   ev_ts,
    output logic [N_NEUR-1:0] pending,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int EV_W = ADDR_W + TS_W;

    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] last_grant;
    logic [N_NEUR-1:0] spike_acc;
    logic [N_NEUR-1:0] grant_oh;
    logic [ADDR_W-1:0] grant_idx;
    logic              grant_vld;
    logic              ovf_hit;
    logic              fifo_full;
    logic [EV_W-1:0]   head;

    // Spikes are only seen while enabled; draining continues regardless.
    assign spike_acc = en ? spike_in : '0;

    // Round-robin pick: first pending bit after last_grant, none while full.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (!fifo_full) begin
            for (int k = 0; k < N_NEUR; k++) begin
                if (!grant_vld && pending[rr_index(int'(last_grant), k + 1, N_NEUR)]) begin
                    grant_vld = 1'b1;
                    grant_idx = ADDR_W'(rr_index(int'(last_grant), k + 1, N_NEUR));
                end
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A spike landing on a pending bit that is not leaving this cycle is lost.
    assign ovf_hit = |(spike_acc & pending & ~grant_oh);

    // Timestamp advances only while enabled and wraps at 2^TS_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else if (en) begin
            ts <= ts + 1'b1;
        end
    end

    // Pending vector, grant history and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            last_grant <= ADDR_W'(N_NEUR - 1);
            overflow   <= 1'b0;
        end else begin
            pending  <= (pending & ~grant_oh) | spike_acc;
            overflow <= ovf_hit | (overflow & ~clr_ovf);
            if (grant_vld) begin
                last_grant <= grant_idx;
            end
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_vld),
        .push_data ({grant_idx, ts}),
        .full      (fifo_full),
        .pop_valid (ev_valid),
        .pop_ready (ev_ready),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign ev_addr = head[TS_W +: ADDR_W];
    assign ev_ts   = head[TS_W-1:0];

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Directed bench for spike_aer_arbiter (N_NEUR=4, FIFO_DEPTH=8, TS_W=4 so the
// timestamp wrap is reachable in a few cycles).
module tb_spike_aer_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] spike_in = '0;
    logic       clr_ovf = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_addr;
    logic [3:0] ev_ts;
    logic [3:0] pending;
    logic [3:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad = 0;

    spike_aer_arbiter #(
        .N_NEUR     (4),
        .FIFO_DEPTH (8),
        .TS_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .clr_ovf    (clr_ovf),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .ev_ts      (ev_ts),
        .pending    (pending),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_b;
        logic       en;
        logic [3:0] spk;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] a;
        logic [3:0] t;
        logic [3:0] c;
        logic [3:0] p;
        logic       o;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        spike_in = '0;
        ev_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input logic e, input logic [3:0] s, input logic r, input logic c);
        en = e;
        spike_in = s;
        ev_ready = r;
        clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst en spk    rdy clr  v  a  t  c  p  o
        // Single spike on neuron 0, then en=0 freezes ts and ignores spikes
        tbl[0]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0001, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'd1, 4'd1, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0010, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'd4, 4'd1, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
        // All four neurons at once, drained in order 0..3
        tbl[8]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b1111, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'd1, 4'd1, 4'b1110, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2, 4'd1, 4'b1100, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'd3, 4'd1, 4'b1000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'd4, 4'd1, 4'b0000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
        // Neuron 2 re-spiking while granted every cycle
        tbl[14] = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0100, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'd1, 4'd1, 4'b0100, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'd2, 4'd1, 4'b0100, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'd3, 4'd1, 4'b0100, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'd4, 4'd1, 4'b0000, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'b0000, 1'b0};

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_addr", int'(ev_addr), 0);
        chk("rst_ts", int'(ev_ts), 0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst_b) do_reset();
            cyc(tbl[i].en, tbl[i].spk, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("row%0d_valid", i), int'(ev_valid), int'(tbl[i].v));
            chk($sformatf("row%0d_count", i), int'(fifo_count), int'(tbl[i].c));
            chk($sformatf("row%0d_pending", i), int'(pending), int'(tbl[i].p));
            chk($sformatf("row%0d_ovf", i), int'(overflow), int'(tbl[i].o));
            chk($sformatf("row%0d_addr", i), int'(ev_addr), int'(tbl[i].a));
            chk($sformatf("row%0d_ts", i), int'(ev_ts), int'(tbl[i].t));
        end

        // FIFO fill: no grant while full even with a pop; overflow set/clear
        do_reset();
        cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("full_e1_pending", int'(pending), 4'b1111);
        cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("full_e2_ovf", int'(overflow), 1);
        chk("full_e2_count", int'(fifo_count), 1);
        repeat (4) cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("full_e6_count", int'(fifo_count), 5);
        repeat (3) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("full_e9_count", int'(fifo_count), 8);
        chk("full_e9_pending", int'(pending), 4'b0001);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("full_hold_count", int'(fifo_count), 8);
        chk("full_hold_pending", int'(pending), 4'b0001);
        chk("full_head_addr", int'(ev_addr), 0);
        chk("full_head_ts", int'(ev_ts), 1);
        cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("full_pop_count", int'(fifo_count), 7);
        chk("full_pop_pending", int'(pending), 4'b0001);
        chk("full_pop_addr", int'(ev_addr), 1);
        chk("full_pop_ts", int'(ev_ts), 2);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("refill_count", int'(fifo_count), 8);
        chk("refill_pending", int'(pending), 0);
        cyc(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow), 0);
        cyc(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("clr2_pending", int'(pending), 4'b0010);
        chk("clr2_ovf", int'(overflow), 0);
        cyc(1'b1, 4'b0010, 1'b0, 1'b1);
        chk("clr_vs_set_ovf", int'(overflow), 1);
        cyc(1'b1, 4'b0000, 1'b0, 1'b1);
        chk("clr3_ovf", int'(overflow), 0);

        // Timestamp wrap 15 -> 0 on back-to-back events from neuron 1
        do_reset();
        repeat (14) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("wrap_pending", int'(pending), 4'b0010);
        cyc(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("wrap_first_ts", int'(ev_ts), 15);
        chk("wrap_first_addr", int'(ev_addr), 1);
        chk("wrap_pending2", int'(pending), 4'b0010);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("wrap_count", int'(fifo_count), 2);
        chk("wrap_hold_ts", int'(ev_ts), 15);
        chk("wrap_ovf", int'(overflow), 0);
        cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("wrap_second_ts", int'(ev_ts), 0);
        chk("wrap_second_addr", int'(ev_addr), 1);

        // Asynchronous reset mid-operation
        do_reset();
        repeat (3) cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0, 1'b0);
        chk("pre_arst_count", int'(fifo_count), 5);
        chk("pre_arst_pending", int'(pending), 4'b0110);
        en = 1'b1;
        spike_in = '0;
        ev_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_pending", int'(pending), 0);
        chk("arst_valid", int'(ev_valid), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_addr", int'(ev_addr), 0);
        chk("arst_ts", int'(ev_ts), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 4'b0000, 1'b1, 1'b0);
            chk($sformatf("post_arst%0d_valid", i), int'(ev_valid), 0);
            chk($sformatf("post_arst%0d_count", i), int'(fifo_count), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
